// File: rtl/ddr_rd_sched_pkg.sv
// Shared types and default widths for the DDR4 read scheduler.
package ddr_rd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_LEN_W  = 16;
  localparam int OUT_CNT_W  = 8;

endpackage

// File: rtl/rd_credit_counter.sv
// Saturating up/down beat counter with a full flag at MAX and an underflow flag.
module rd_credit_counter #(
  parameter int W   = 8,
  parameter int MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         underflow
);

  localparam logic [W-1:0] MAX_C = W'(MAX);
  localparam logic [W-1:0] ONE   = W'(1);

  logic [W-1:0] count_q, count_d;
  logic         do_inc, do_dec;

  // Decrement from zero is flagged and dropped; increment at all-ones is dropped.
  always_comb begin
    underflow = dec && (count_q == '0);
    do_dec    = dec && !underflow;
    do_inc    = inc && ((count_q != '1) || do_dec);
    count_d   = count_q;
    if (do_inc && !do_dec)      count_d = count_q + ONE;
    else if (do_dec && !do_inc) count_d = count_q - ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign full  = (count_q >= MAX_C);

endmodule

// File: rtl/ddr_rd_scheduler.sv
// Splits read jobs into per-beat DDR4 requests, credit-limited by downstream consumption.
// Optional RD_SCHED_STATS_EN adds stall_cycles / beats_total statistics outputs.
module ddr_rd_scheduler
  import ddr_rd_sched_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int ADDR_STEP = 8,
  parameter int MAX_OUT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] job_addr,
  input  logic [LEN_W-1:0]  job_len,
  input  logic              job_valid,
  output logic              job_ready,
  output logic              ddr_rd_req_valid,
  output logic [ADDR_W-1:0] ddr_rd_req_addr,
  input  logic              ddr_rd_req_ready,
  input  logic              ddr_rd_valid,
  input  logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              done,
  output logic [OUT_CNT_W-1:0] outstanding,
  output logic              err
`ifdef RD_SCHED_STATS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       beats_total
`endif
);

  localparam logic [ADDR_W-1:0] STEP_C = ADDR_W'(ADDR_STEP);
  localparam logic [LEN_W-1:0]  LEN_1  = LEN_W'(1);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [LEN_W-1:0]  consumed_q, consumed_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              req_fire, consume;
  logic              out_full, out_underflow;
  logic              pend_underflow, pend_full_unused;
  logic [OUT_CNT_W-1:0] pend_count_unused;

  assign consume          = m_axis_tvalid & m_axis_tready;
  assign ddr_rd_req_valid = (state_q == ISSUE) && !out_full;
  assign req_fire         = ddr_rd_req_valid & ddr_rd_req_ready;

  rd_credit_counter #(.W(OUT_CNT_W), .MAX(MAX_OUT)) u_outstanding (
    .clk      (clk),
    .rst      (rst),
    .inc      (req_fire),
    .dec      (consume),
    .count    (outstanding),
    .full     (out_full),
    .underflow(out_underflow)
  );

  rd_credit_counter #(.W(OUT_CNT_W), .MAX(255)) u_pending_ret (
    .clk      (clk),
    .rst      (rst),
    .inc      (req_fire),
    .dec      (ddr_rd_valid),
    .count    (pend_count_unused),
    .full     (pend_full_unused),
    .underflow(pend_underflow)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    consumed_d  = consumed_q;
    done_d      = 1'b0;
    err_d       = err_q | out_underflow | pend_underflow | (consume && (state_q == IDLE));

    if (consume && (state_q != IDLE) && (consumed_q != '1)) consumed_d = consumed_q + LEN_1;

    case (state_q)
      IDLE: begin
        if (job_valid) begin
          if (job_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = job_addr;
            len_d       = job_len;
            remaining_d = job_len;
            consumed_d  = '0;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (req_fire) begin
          addr_d      = addr_q + STEP_C;
          remaining_d = remaining_q - LEN_1;
          if (remaining_q == LEN_1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Finishing on the final consume edge lets done and job_ready coincide.
        if (consumed_d >= len_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      consumed_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      consumed_q  <= consumed_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign job_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign err             = err_q;
  assign ddr_rd_req_addr = addr_q;

`ifdef RD_SCHED_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] beats_q, beats_d;

  always_comb begin
    stall_d = stall_q;
    beats_d = beats_q;
    if ((state_q == ISSUE) && out_full && (stall_q != '1)) stall_d = stall_q + 32'd1;
    if (consume && (beats_q != '1))                        beats_d = beats_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      beats_q <= '0;
    end else begin
      stall_q <= stall_d;
      beats_q <= beats_d;
    end
  end

  assign stall_cycles = stall_q;
  assign beats_total  = beats_q;
`endif

endmodule

// File: tb/tb_ddr_rd_scheduler.sv
// Random and directed checks of ddr_rd_scheduler against a beat-counting reference model.
module tb_ddr_rd_scheduler;

  localparam int AW   = 28;
  localparam int LW   = 16;
  localparam int STEP = 8;
  localparam int MO   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] job_addr = '0;
  logic [LW-1:0] job_len = '0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic          ddr_rd_req_valid;
  logic [AW-1:0] ddr_rd_req_addr;
  logic          ddr_rd_req_ready = 1'b0;
  logic          ddr_rd_valid = 1'b0;
  logic          m_axis_tvalid = 1'b0;
  logic          m_axis_tready = 1'b0;
  logic          busy, done, err;
  logic [7:0]    outstanding;
`ifdef RD_SCHED_STATS_EN
  logic [31:0]   stall_cycles, beats_total;
`endif

  always #5 clk = ~clk;

  ddr_rd_scheduler #(.ADDR_W(AW), .LEN_W(LW), .ADDR_STEP(STEP), .MAX_OUT(MO)) dut (
    .clk              (clk),
    .rst              (rst),
    .job_addr         (job_addr),
    .job_len          (job_len),
    .job_valid        (job_valid),
    .job_ready        (job_ready),
    .ddr_rd_req_valid (ddr_rd_req_valid),
    .ddr_rd_req_addr  (ddr_rd_req_addr),
    .ddr_rd_req_ready (ddr_rd_req_ready),
    .ddr_rd_valid     (ddr_rd_valid),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .busy             (busy),
    .done             (done),
    .outstanding      (outstanding),
    .err              (err)
`ifdef RD_SCHED_STATS_EN
    ,
    .stall_cycles     (stall_cycles),
    .beats_total      (beats_total)
`endif
  );

  int total = 0, bad = 0, cyc = 0, prints = 0;

  // Environment knobs and state (adapter return queue, stream FIFO occupancy)
  int p_rr = 100, p_tr = 100, p_rv = 100;
  bit force_rv = 0, force_tr = 0;
  int ret_n = 0, fifo_n = 0;

  // Reference model: job progress expressed as beat counts
  bit            m_busy = 0, m_done = 0, m_err = 0;
  int            m_left = 0, m_len = 0, m_cons = 0, m_out = 0, m_pend = 0;
  logic [AW-1:0] m_addr = '0;

  logic [AW-1:0] hs_addr[$];
  int            hs_cyc[$];
  int            done_seen = 0, done_cyc = 0, last_cons_cyc = 0, busy_seen = 0;

  function automatic bit m_valid();
    return m_busy && (m_left > 0) && (m_out < MO);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit cons, hs, draining, pdec;
    cyc++;
    cons = m_axis_tvalid & m_axis_tready;
    hs   = m_valid() & ddr_rd_req_ready;
    if (rst) begin
      m_busy = 0; m_done = 0; m_err = 0; m_left = 0; m_len = 0; m_cons = 0;
      m_out = 0; m_pend = 0; m_addr = '0; ret_n = 0; fifo_n = 0;
    end else begin
      if (ddr_rd_valid && ret_n > 0) begin ret_n--; fifo_n++; end
      if (hs) ret_n++;
      if (cons && fifo_n > 0) fifo_n--;
      if (cons) last_cons_cyc = cyc;
      if (hs) begin hs_addr.push_back(m_addr); hs_cyc.push_back(cyc); end

      m_err = m_err | (cons && m_out == 0) | (ddr_rd_valid && m_pend == 0) | (cons && !m_busy);
      m_out = m_out + (hs ? 1 : 0) - ((cons && m_out > 0) ? 1 : 0);
      pdec  = ddr_rd_valid && m_pend > 0;
      m_pend = m_pend + ((hs && (m_pend < 255 || pdec)) ? 1 : 0) - (pdec ? 1 : 0);
      m_done = 0;
      if (!m_busy) begin
        if (job_valid) begin
          if (job_len == 0) m_done = 1;
          else begin
            m_busy = 1; m_left = job_len; m_len = job_len; m_addr = job_addr; m_cons = 0;
          end
        end
      end else begin
        draining = (m_left == 0);
        if (hs) begin m_addr = m_addr + AW'(STEP); m_left--; end
        if (cons) m_cons++;
        if (draining && m_cons >= m_len) begin m_busy = 0; m_done = 1; end
      end
    end
    #1;
    total++;
    if ({job_ready, ddr_rd_req_valid, ddr_rd_req_addr, busy, done, outstanding, err} !==
        {!m_busy, m_valid(), m_addr, m_busy, m_done, 8'(m_out), m_err}) begin
      bad++;
      if (prints < 20) begin
        prints++;
        $display("FAIL cycle_cmp @%0d: got rdy=%b v=%b a=%h busy=%b done=%b out=%0d err=%b expected rdy=%b v=%b a=%h busy=%b done=%b out=%0d err=%b",
                 cyc, job_ready, ddr_rd_req_valid, ddr_rd_req_addr, busy, done, outstanding, err,
                 !m_busy, m_valid(), m_addr, m_busy, m_done, m_out, m_err);
      end
    end
    if (done) begin done_seen++; done_cyc = cyc; end
    if (busy) busy_seen++;
  end

  task automatic drive();
    ddr_rd_req_ready = ($urandom_range(99) < p_rr);
    m_axis_tready    = force_tr || ($urandom_range(99) < p_tr);
    ddr_rd_valid     = force_rv || (ret_n > 0 && $urandom_range(99) < p_rv);
    m_axis_tvalid    = (fifo_n > 0);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); drive(); end
  endtask

  task automatic send_job(input logic [AW-1:0] a, input int len);
    int k = 0;
    @(negedge clk); drive();
    while (m_busy && k < 2000) begin @(negedge clk); drive(); k++; end
    if (m_busy) chk("job_wait_timeout", 1, 0);
    job_addr = a; job_len = LW'(len); job_valid = 1'b1;
    @(negedge clk); job_valid = 1'b0; drive();
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (m_busy && k < budget) begin @(negedge clk); drive(); k++; end
    if (m_busy) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    int base, k;
    step(3);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_req_valid", ddr_rd_req_valid, 0);
    chk("rst_req_addr", ddr_rd_req_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    step(2);

    // Basic job
    hs_addr.delete(); hs_cyc.delete(); base = done_seen;
    send_job(28'h100, 3); wait_idle(50); step(2);
    chk("basic_count", hs_addr.size(), 3);
    chk("basic_a0", hs_addr[0], 28'h100);
    chk("basic_a1", hs_addr[1], 28'h108);
    chk("basic_a2", hs_addr[2], 28'h110);
    chk("basic_b2b_1", hs_cyc[1] - hs_cyc[0], 1);
    chk("basic_b2b_2", hs_cyc[2] - hs_cyc[1], 1);
    chk("basic_done_cnt", done_seen - base, 1);
    chk("basic_done_after_consume", done_cyc, last_cons_cyc);
    chk("basic_out_end", outstanding, 0);

    // Backpressure: credit stops issue at MAX_OUT
    hs_addr.delete(); p_tr = 0;
    send_job(28'h4000, 10); step(15);
    chk("bp_issued", hs_addr.size(), 4);
    chk("bp_valid_low", ddr_rd_req_valid, 0);
    chk("bp_outstanding", outstanding, 4);
    force_tr = 1; step(1); force_tr = 0; step(8);
    chk("bp_one_release", hs_addr.size(), 5);
    chk("bp_valid_low2", ddr_rd_req_valid, 0);
    p_tr = 100; wait_idle(200);
    chk("bp_total", hs_addr.size(), 10);
    chk("bp_last_addr", hs_addr[9], 28'h4048);

    // Zero-length job
    hs_addr.delete(); base = done_seen; busy_seen = 0;
    send_job(28'h777, 0); step(5);
    chk("zero_done_cnt", done_seen - base, 1);
    chk("zero_busy", busy_seen, 0);
    chk("zero_no_req", hs_addr.size(), 0);

    // Address wrap
    hs_addr.delete();
    send_job(28'hFFFFFF8, 2); wait_idle(50);
    chk("wrap_a0", hs_addr[0], 28'hFFFFFF8);
    chk("wrap_a1", hs_addr[1], 28'h0);

    // Spurious return in IDLE
    step(2);
    @(negedge clk); force_rv = 1; drive(); force_rv = 0;
    step(1);
    chk("err_set", err, 1);
    send_job(28'h200, 2); wait_idle(50); step(1);
    chk("err_sticky", err, 1);
    @(negedge clk); rst = 1'b1; step(2); @(negedge clk); rst = 1'b0; drive();
    chk("err_cleared", err, 0);

    // Reset mid-job
    hs_addr.delete(); p_tr = 0;
    send_job(28'h8000, 8);
    k = 0;
    while (hs_addr.size() < 3 && k < 50) begin @(negedge clk); drive(); k++; end
    chk("mid_issued3", hs_addr.size(), 3);
    #2 rst = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_outstanding", outstanding, 0);
    chk("mid_job_ready", job_ready, 1);
    step(2); @(negedge clk); rst = 1'b0; p_tr = 100; drive();
    hs_addr.delete();
    send_job(28'h9000, 4); wait_idle(50);
    chk("mid_next_count", hs_addr.size(), 4);
    chk("mid_next_addr", hs_addr[0], 28'h9000);

    // Randomized jobs
    base = done_seen;
    for (int j = 0; j < 40; j++) begin
      p_rr = 30 + $urandom_range(70);
      p_tr = 30 + $urandom_range(70);
      p_rv = 30 + $urandom_range(70);
      send_job(AW'($urandom), $urandom_range(12));
    end
    wait_idle(2000); step(3);
    chk("rand_done_cnt", done_seen - base, 40);
    chk("rand_err", err, 0);
    chk("rand_out_end", outstanding, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
